// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 constants, FSM state type and the FIPS 180-4
//               logical functions used by the compression engine.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RND  = 1'b1
    } fsm_state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round
// Description : One combinational SHA-256 compression round.
//   i_state [255:0] : working variables a..h, a at [255:224]
//   i_w     [31:0]  : message schedule word W[t]
//   i_k     [31:0]  : round constant K[t]
//   o_state [255:0] : a..h after the round
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_w,
    input  logic [31:0]  i_k,
    output logic [255:0] o_state
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_t1 = w_h + bsig1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = bsig0(w_a) + maj(w_a, w_b, w_c);

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule
`default_nettype wire

// File: rtl/sha256_inc_core.sv
`default_nettype none
// ============================================================================
// Module      : sha256_inc_core
// Description : Incremental SHA-256 compression engine. Accepts one 512-bit
//               block per request plus an external chaining state, tracks the
//               message byte count and pads the final request.
//   clk, rstn (sync, active-low)
//   sha256_start/1st/final  : request pulse and message position flags
//   sha256_state [255:0]    : chaining value H0..H7 (H0 at MSBs)
//   sha256_data  [511:0]    : block bytes, byte 0 at MSBs
//   sha256_len   [6:0]      : valid bytes on the final request
//   sha256_done             : one-cycle completion pulse
//   sha256_dout  [255:0]    : updated state, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_inc_core
    import sha256_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sha256_start,
    input  logic                 sha256_1st,
    input  logic                 sha256_final,
    input  logic [255:0]         sha256_state,
    input  logic [511:0]         sha256_data,
    input  logic [6:0]           sha256_len,
    output logic                 sha256_done,
    output logic [255:0]         sha256_dout
);

    fsm_state_t             r_state, w_state_nxt;
    logic [5:0]             r_rnd;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [255:0]           r_h, r_work, r_dout;
    logic [511:0]           r_w, r_pad2;
    logic                   r_pend, r_done;

    logic                   w_accept, w_last, w_two;
    logic [6:0]             w_n;
    logic [CNT_WIDTH-1:0]   w_base, w_sum;
    logic [63:0]            w_bitlen;
    logic [511:0]           w_blk1, w_blk2;
    logic [31:0]            w_wnew;
    logic [255:0]           w_work_nxt, w_hsum;

    assign w_accept = (r_state == ST_IDLE) && sha256_start;
    assign w_last   = (r_state == ST_RND) && (r_rnd == 6'd63);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (sha256_start)      w_state_nxt = ST_RND;
            ST_RND:  if (w_last && !r_pend) w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Pad-block builder ----------------
    // Lengths above 64 are clamped so an illegal len behaves as a full block.
    assign w_n      = (sha256_len > 7'd64) ? 7'd64 : sha256_len;
    assign w_base   = sha256_1st ? '0 : r_cnt;
    assign w_sum    = w_base + CNT_WIDTH'(w_n);
    assign w_bitlen = 64'(w_sum) << 3;

    always_comb begin
        w_blk1 = '0;
        w_blk2 = '0;
        w_two  = 1'b0;
        if (!sha256_final) begin
            w_blk1 = sha256_data;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (i < int'(w_n))
                    w_blk1[511-8*i -: 8] = sha256_data[511-8*i -: 8];
                else if (i == int'(w_n))
                    w_blk1[511-8*i -: 8] = 8'h80;
            end
            if (w_n <= 7'd55) begin
                w_blk1[63:0] = w_bitlen;
            end else begin
                // Length field does not fit: it moves to a second block,
                // which also carries the 0x80 marker when the data was full.
                w_two        = 1'b1;
                w_blk2[63:0] = w_bitlen;
                if (w_n == 7'd64) w_blk2[511:504] = 8'h80;
            end
        end
    end

    // ---------------- Round and schedule ----------------
    // r_w holds W[t..t+15] with W[t] in the top word.
    assign w_wnew = ssig1(r_w[63:32]) + r_w[223:192] + ssig0(r_w[479:448]) + r_w[511:480];

    sha256_round u_round (
        .i_state (r_work),
        .i_w     (r_w[511:480]),
        .i_k     (K[r_rnd]),
        .o_state (w_work_nxt)
    );

    for (genvar j = 0; j < 8; j++) begin : g_hsum
        assign w_hsum[32*j +: 32] = r_h[32*j +: 32] + w_work_nxt[32*j +: 32];
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rnd  <= '0;
            r_cnt  <= '0;
            r_h    <= '0;
            r_work <= '0;
            r_w    <= '0;
            r_pad2 <= '0;
            r_pend <= 1'b0;
            r_done <= 1'b0;
            r_dout <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_work <= sha256_state;
                r_h    <= sha256_state;
                r_w    <= w_blk1;
                r_pad2 <= w_blk2;
                r_pend <= w_two;
                r_rnd  <= '0;
                if (!sha256_final) r_cnt <= w_base + CNT_WIDTH'(64);
            end else if (r_state == ST_RND) begin
                r_rnd <= r_rnd + 6'd1;
                if (w_last) begin
                    r_h <= w_hsum;
                    if (r_pend) begin
                        r_work <= w_hsum;
                        r_w    <= r_pad2;
                        r_pend <= 1'b0;
                    end else begin
                        r_dout <= w_hsum;
                        r_done <= 1'b1;
                    end
                end else begin
                    r_work <= w_work_nxt;
                    r_w    <= {r_w[479:0], w_wnew};
                end
            end
        end
    end

    assign sha256_done = r_done;
    assign sha256_dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_sha256_inc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_inc_core
// Description : Directed self-checking bench for sha256_inc_core using known
//               SHA-256 digests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_inc_core;

    logic         clk = 1'b0;
    logic         rstn;
    logic         sha256_start, sha256_1st, sha256_final;
    logic [255:0] sha256_state;
    logic [511:0] sha256_data;
    logic [6:0]   sha256_len;
    logic         sha256_done;
    logic [255:0] sha256_dout;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_64A   = 256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb;
    localparam logic [511:0] BLK_ABC = {24'h616263, 488'h0};
    localparam logic [511:0] BLK_64A = {64{8'h61}};

    always #5 clk = ~clk;

    sha256_inc_core #(.CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sha256_start (sha256_start),
        .sha256_1st   (sha256_1st),
        .sha256_final (sha256_final),
        .sha256_state (sha256_state),
        .sha256_data  (sha256_data),
        .sha256_len   (sha256_len),
        .sha256_done  (sha256_done),
        .sha256_dout  (sha256_dout)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic first, input logic fin, input logic [6:0] len,
                           input logic [255:0] st, input logic [511:0] data);
        sha256_start = 1'b1;
        sha256_1st   = first;
        sha256_final = fin;
        sha256_len   = len;
        sha256_state = st;
        sha256_data  = data;
    endtask

    // Issues a request in cycle T and returns the digest and the cycle offset
    // of done relative to T (-1 if done never came).
    task automatic run_req(input logic first, input logic fin, input logic [6:0] len,
                           input logic [255:0] st, input logic [511:0] data,
                           output logic [255:0] dig, output int lat);
        @(negedge clk);
        set_req(first, fin, len, st, data);
        @(negedge clk);
        sha256_start = 1'b0;
        lat = 1;
        while (!sha256_done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!sha256_done) lat = -1;
        dig = sha256_dout;
    endtask

    logic [255:0] dig, dig1;
    logic [447:0] msg448;
    int           lat, ndone, d1, d2;
    logic [255:0] dout_at_d2;

    initial begin
        rstn = 1'b0;
        sha256_start = 1'b0; sha256_1st = 1'b0; sha256_final = 1'b0;
        sha256_len = '0; sha256_state = '0; sha256_data = '0;
        repeat (3) @(negedge clk);
        check("reset_done", 256'(sha256_done), 256'd0);
        check("reset_dout", sha256_dout, 256'd0);
        rstn = 1'b1;

        // "abc"
        run_req(1'b1, 1'b1, 7'd3, IV, BLK_ABC, dig, lat);
        check("abc_digest", dig, D_ABC);
        check("abc_latency", 256'(lat), 256'd65);
        repeat (5) @(negedge clk);
        check("abc_dout_held", sha256_dout, D_ABC);
        check("done_one_cycle", 256'(sha256_done), 256'd0);

        // empty message
        run_req(1'b1, 1'b1, 7'd0, IV, 512'd0, dig, lat);
        check("empty_digest", dig, D_EMPTY);

        // 56-byte message: two-block final
        msg448 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        run_req(1'b1, 1'b1, 7'd56, IV, {msg448, 64'h0}, dig, lat);
        check("len56_digest", dig, D_448);
        check("len56_latency", 256'(lat), 256'd129);

        // 64 x 'a': full block, then empty final with chaining
        run_req(1'b1, 1'b0, 7'd0, IV, BLK_64A, dig1, lat);
        check("blk64_latency", 256'(lat), 256'd65);
        run_req(1'b0, 1'b1, 7'd0, dig1, 512'd0, dig, lat);
        check("chain_digest", dig, D_64A);
        run_req(1'b1, 1'b1, 7'd64, IV, BLK_64A, dig, lat);
        check("len64_digest", dig, D_64A);
        check("len64_latency", 256'(lat), 256'd129);
        run_req(1'b1, 1'b1, 7'd100, IV, BLK_64A, dig, lat);
        check("len_over64_digest", dig, D_64A);

        // Busy-ignore and start accepted in the done cycle
        @(negedge clk);
        set_req(1'b1, 1'b1, 7'd3, IV, BLK_ABC);
        ndone = 0; d1 = -1; d2 = -1; dout_at_d2 = '0;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (sha256_done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = c;
                    check("busy_digest", sha256_dout, D_ABC);
                end else if (d2 < 0) begin
                    d2 = c;
                    dout_at_d2 = sha256_dout;
                end
            end
            if (c == 10)      set_req(1'b1, 1'b1, 7'd64, ~IV, {64{8'h55}});
            else if (c == 65) set_req(1'b1, 1'b1, 7'd0, IV, 512'd0);
            else              sha256_start = 1'b0;
        end
        check("busy_first_done", 256'(d1), 256'd65);
        check("b2b_second_done", 256'(d2), 256'd130);
        check("busy_done_count", 256'(ndone), 256'd2);
        check("b2b_digest", dout_at_d2, D_EMPTY);

        // Reset in flight
        @(negedge clk);
        set_req(1'b1, 1'b1, 7'd3, IV, BLK_ABC);
        ndone = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            sha256_start = 1'b0;
            if (sha256_done) ndone++;
            if (c == 30)      rstn = 1'b0;
            else if (c == 32) rstn = 1'b1;
        end
        check("rst_no_done", 256'(ndone), 256'd0);
        check("rst_dout_zero", sha256_dout, 256'd0);
        run_req(1'b1, 1'b1, 7'd3, IV, BLK_ABC, dig, lat);
        check("post_rst_digest", dig, D_ABC);
        check("post_rst_latency", 256'(lat), 256'd65);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_inc_core.md
# sha256_inc_core

Incremental SHA-256 compression engine: the responder side of the `sha256_start / sha256_1st / sha256_final / sha256_state / sha256_data / sha256_len / sha256_done / sha256_dout` handshake driven by the message-random, PRF and hash-chain controllers. It accepts one 512-bit block per request together with an external chaining state. It tracks the running byte count across a message, applies FIPS 180-4 padding on the final request, and returns the updated 256-bit state.

## Interface
- `CNT_WIDTH`, default 32: width of the internal message byte counter; the length field is `{zero-extend(cnt), 3'b000}` to 64 bits.
- `clk  in  1`: clock.
- `rstn  in  1`: reset, synchronous, active-low.
- `sha256_start  in  1`: one-cycle request pulse; other inputs are sampled only in this cycle.
- `sha256_1st  in  1`: first block of a new message; clears the byte counter before this block is counted.
- `sha256_final  in  1`: last request of the message; padding is applied.
- `sha256_state  in  256`: chaining value H0..H7, with H0 at [255:224]. The caller supplies IV on the first block.
- `sha256_data  in  512`: block bytes, with byte 0 at [511:504].
- `sha256_len  in  7`: valid bytes, 0..64. Ignored (treated as 64) when `sha256_final`=0.
- `sha256_done  out  1`: one-cycle completion pulse; reset 0.
- `sha256_dout  out  256`: resulting state, held until the next `done`; reset 0.

## Operation
- FSM states:
  - IDLE → RND on `sha256_start`; `start` is ignored in every other state, with no queuing.
  - RND: 64 cycles, round counter 0..63, one round per cycle. A 16-word W shift register computes W[t] on the fly.
  - At round 63: H ← H + a..h.
    - If a second pad block is pending: reload a..h from the new H, load W from the pad block, clear the round counter, and stay in RND.
    - Otherwise: write `sha256_dout`, pulse `done`, go to IDLE.
- Byte counter `cnt`:
  - On an accepted start, `base` = 0 if `1st`=1, else `cnt`.
  - Non-final request: `cnt` ← `base` + 64.
  - Final request: bit length L = (`base` + `len`)·8. `cnt` is left unchanged afterwards.
  - Wraps modulo 2^CNT_WIDTH; no error indication.
- Final block construction, with `len` = n:
  - Bytes 0..n-1 come from data; byte n = 0x80 when n<64; all remaining bytes are 0.
  - n ≤ 55: a single block, with bytes 56..63 = L big-endian.
  - 56 ≤ n ≤ 63: two blocks. Block 2 is all zero except bytes 56..63 = L.
  - n = 64: two blocks. Block 2 has byte 0 = 0x80 and bytes 56..63 = L.
- `len` > 64 on a final request is illegal; the core treats it as 64.
- Reset (any state): FSM to IDLE, `cnt`, H, a..h and round counter to 0, `done` to 0, `dout` to 0. An in-flight request is dropped with no `done`.

## Timing
- Request sampled at the rising edge ending cycle T (`start` high in T).
- One-block request: rounds in cycles T+1..T+64; `done`=1 and `dout` valid in cycle T+65.
- Two-block final request: `done` in cycle T+129.
- `done` is high for exactly one cycle. The core is idle in the `done` cycle, so a new `start` in that same cycle is accepted (back-to-back throughput of 65 cycles per block).
- `dout` changes only on the edge that raises `done`.

## Structure
- Package `sha256_pkg`: K[0..63] constant array, IV_256, and functions `ch`, `maj`, `bsig0`, `bsig1`, `ssig0`, `ssig1`.
- One sub-module `sha256_round`: purely combinational. Takes a..h, W[t] and K[t]; returns the next a..h.
- Top level holds the FSM, byte counter, pad-block builder, W scheduler and H registers; about 250 RTL lines.

## Test plan
1. `1st`=1, `final`=1, `len`=3, data="abc", state=IV → `done` at T+65, `dout`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
2. `len`=0, `1st`=`final`=1, state=IV → `dout`=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
3. `len`=56 with "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → `done` at T+129, `dout`=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
4. Block of 64×'a' (`1st`=1, `final`=0), `dout` fed back as state, then `final`=1 with `len`=0 → `dout`=ffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb; `len`=64 variant of the final request produces the same digest.
5. Second `start` with different data at T+10 during a busy request → ignored, exactly one `done`, digest matches the first request; `start` in the `done` cycle is accepted.
6. `rstn`=0 at T+30 of a request → no `done`, `dout`=0. A fresh "abc" request afterwards matches scenario 1.
